// File: rtl/transmitting_pkg.sv
// Shared definitions for the serial transmitter: FSM encoding, default
// parameters and a counter-width helper.
package transmitting_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;
  localparam int FRAME_BITS       = DATA_BITS_DEF + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Minimum of one bit so a terminal count of 0 still has a register.
  function automatic int width_of(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/transmitting_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each serial bit with wrap_o.
module tx_bit_timer
  import transmitting_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int CNT_W = width_of(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = en_i & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (wrap_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitting.sv
// Serial character transmitter: start bit, DATA_BITS data bits LSB first,
// stop bit; every output is registered.
module transmitting
  import transmitting_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 data_out,
  output logic                 busy,
  output logic                 charSent
);

  localparam int IDX_W = width_of(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 data_out_q, data_out_d;
  logic                 busy_q, busy_d;
  logic                 char_sent_q, char_sent_d;
  logic                 timer_clr_s;
  logic                 timer_en_s;
  logic                 bit_wrap_s;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (timer_clr_s),
    .en_i   (timer_en_s),
    .wrap_o (bit_wrap_s)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    char_sent_d = 1'b0;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        timer_en_s  = 1'b0;
        idx_d       = '0;
        if (load) begin
          shift_d    = data_in;
          state_d    = ST_START;
          data_out_d = 1'b0;
        end else begin
          data_out_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_wrap_s) begin
          state_d    = ST_DATA;
          idx_d      = '0;
          data_out_d = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_wrap_s) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_STOP;
            data_out_d = 1'b1;
          end else begin
            // Next bit is always presented from the LSB of the shifted word.
            shift_d    = shift_q >> 1'b1;
            data_out_d = shift_d[0];
            idx_d      = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_wrap_s) begin
          state_d     = ST_IDLE;
          char_sent_d = 1'b1;
          data_out_d  = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        data_out_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      data_out_q  <= 1'b1;
      busy_q      <= 1'b0;
      char_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      char_sent_q <= char_sent_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign charSent = char_sent_q;

endmodule

// File: tb/tb_transmitting.sv
// Self-checking bench: two transmitters (16 and 4 clocks per bit) compared
// cycle by cycle against an arithmetic model of the serial frame.
module tb_transmitting;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_a = 1'b0;
  logic       load_b = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       a_do, a_busy, a_cs;
  logic       b_do, b_busy, b_cs;
  logic       use_fast = 1'b0;
  logic       obs_do, obs_busy, obs_cs;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  transmitting #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .data_in(data_a),
    .data_out(a_do), .busy(a_busy), .charSent(a_cs)
  );

  transmitting #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .data_in(data_b),
    .data_out(b_do), .busy(b_busy), .charSent(b_cs)
  );

  assign obs_do   = use_fast ? b_do   : a_do;
  assign obs_busy = use_fast ? b_busy : a_busy;
  assign obs_cs   = use_fast ? b_cs   : a_cs;

  // Line level k cycles after the start bit begins: bit slot = k / cpb.
  function automatic logic model_line(input logic [7:0] ch, input int k, input int cpb);
    int slot;
    slot = k / cpb;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return ch[slot-1];
    else return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic ld, input logic [7:0] d);
    if (use_fast) begin
      load_b = ld;
      data_b = d;
    end else begin
      load_a = ld;
      data_a = d;
    end
  endtask

  // Request ch, then follow the whole frame; hold keeps load high with a
  // scrambled data_in throughout. Returns in the charSent cycle.
  task automatic send_frame(input logic [7:0] ch, input int cpb, input bit hold);
    drive_load(1'b1, ch);
    step();
    for (int k = 0; k < 10 * cpb; k++) begin
      tests_run++;
      if (obs_do !== model_line(ch, k, cpb) || obs_busy !== 1'b1 || obs_cs !== 1'b0) begin
        tests_failed++;
        $display("FAIL frame ch=%h cpb=%0d k=%0d: got data_out=%b busy=%b charSent=%b, want %b 1 0",
                 ch, cpb, k, obs_do, obs_busy, obs_cs, model_line(ch, k, cpb));
      end
      drive_load(hold, 8'($urandom));
      step();
    end
    tests_run++;
    if (obs_cs !== 1'b1 || obs_busy !== 1'b0 || obs_do !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_end ch=%h: got charSent=%b busy=%b data_out=%b, want 1 0 1",
               ch, obs_cs, obs_busy, obs_do);
    end
    drive_load(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tests_run++;
      if (a_do !== 1'b1 || a_busy !== 1'b0 || a_cs !== 1'b0 ||
          b_do !== 1'b1 || b_busy !== 1'b0 || b_cs !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d: got a=%b%b%b b=%b%b%b, want 100 100",
                 i, a_do, a_busy, a_cs, b_do, b_busy, b_cs);
      end
      step();
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    load_a = 1'b1;
    data_a = 8'h00;
    step();
    tests_run++;
    if (a_do !== 1'b1 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_priority: got data_out=%b busy=%b, want 1 0", a_do, a_busy);
    end
    reset = 1'b0;
    load_a = 1'b0;
    step();
  endtask

  task automatic test_single_0x55();
    use_fast = 1'b0;
    send_frame(8'h55, 16, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    use_fast = 1'b0;
    send_frame(8'hA3, 16, 1'b0);
    send_frame(8'h0F, 16, 1'b0);
    step();
  endtask

  task automatic test_hold_load();
    use_fast = 1'b0;
    send_frame(8'hFF, 16, 1'b1);
    send_frame(8'($urandom), 16, 1'b0);
    step();
  endtask

  task automatic test_midframe_reset();
    use_fast = 1'b0;
    drive_load(1'b1, 8'h3C);
    step();
    drive_load(1'b0, 8'h00);
    for (int i = 0; i < 70; i++) step();
    reset = 1'b1;
    step();
    tests_run++;
    if (a_do !== 1'b1 || a_busy !== 1'b0 || a_cs !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset: got data_out=%b busy=%b charSent=%b, want 1 0 0",
               a_do, a_busy, a_cs);
    end
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      tests_run++;
      if (a_cs !== 1'b0 || a_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL aborted_frame cyc=%0d: got charSent=%b busy=%b, want 0 0", i, a_cs, a_busy);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    use_fast = 1'b0;
    for (int n = 0; n < 6; n++) begin
      send_frame(8'($urandom), 16, 1'b0);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        tests_run++;
        if (a_do !== 1'b1 || a_busy !== 1'b0 || a_cs !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_gap n=%0d g=%0d: got %b%b%b, want 100", n, g, a_do, a_busy, a_cs);
        end
      end
    end
    step();
  endtask

  task automatic test_fast_clock();
    use_fast = 1'b1;
    send_frame(8'h81, 4, 1'b0);
    send_frame(8'($urandom), 4, 1'b0);
    step();
    use_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_priority();
    test_single_0x55();
    test_back_to_back();
    test_hold_load();
    test_midframe_reset();
    test_random();
    test_fast_clock();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/transmitting.md
TRANSMITTING -- requirements
Module: transmitting

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16; clock cycles each serial bit is held, matching the receiver's 16x bit-sample count.
REQ-002 Parameter DATA_BITS, default 8; payload bits per character.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  request to send data_in; sampled on each rising clk edge.
REQ-006 data_in  input  DATA_BITS  parallel character to transmit.
REQ-007 data_out  output  1  registered serial line; idles high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 charSent  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 The frame SHALL be 10 bits: one start bit (0), DATA_BITS data bits LSB first, and one stop bit (1).
REQ-011 The FSM SHALL use states IDLE, START, DATA and STOP.
REQ-012 In IDLE, load=1 SHALL latch data_in into an internal shift register and move the FSM to START on the same edge.
REQ-013 data_out SHALL go low on the edge that accepts load, giving one cycle of latency from load to start bit.
REQ-014 Each bit SHALL be held on data_out for exactly CLKS_PER_BIT cycles, timed by a bit counter running 0..CLKS_PER_BIT-1 that wraps to 0.
REQ-015 START SHALL go to DATA when the bit counter wraps; data_out SHALL then present bit 0.
REQ-016 In DATA, a bit index 0..DATA_BITS-1 SHALL advance on each bit-counter wrap; after bit DATA_BITS-1 wraps, the FSM SHALL enter STOP with data_out=1.
REQ-017 STOP SHALL last CLKS_PER_BIT cycles; on its wrap the FSM SHALL return to IDLE and pulse charSent high for exactly that one following cycle.
REQ-018 Total frame duration from the start-bit edge to the end of the stop bit SHALL be 10*CLKS_PER_BIT cycles (160 at default).
REQ-019 busy SHALL be high in START, DATA and STOP, and low in IDLE, including the cycle in which charSent is high.
REQ-020 load SHALL be ignored while busy=1; the latched character SHALL NOT change mid-frame.
REQ-021 load=1 during the charSent cycle SHALL be accepted, so back-to-back frames have no idle gap beyond that one cycle.
REQ-022 A change on data_in after acceptance SHALL NOT affect the frame being sent.
REQ-023 The counter and index widths SHALL be sized with ceil(log2()) of their parameters; no counter SHALL exceed its terminal value.

Reset
REQ-024 reset=1 SHALL force, at the next clk edge:
  - state=IDLE
  - data_out=1
  - busy=0
  - charSent=0
  - bit counter and bit index = 0
  - shift register = 0
REQ-025 reset SHALL take priority over load.
REQ-026 reset asserted mid-frame SHALL abort the frame; no charSent pulse SHALL be produced for the aborted frame.

Structure
REQ-027 A shared package SHALL hold:
  - the FSM state encoding
  - CLKS_PER_BIT and DATA_BITS defaults
  - FRAME_BITS=DATA_BITS+2
REQ-028 Bit timing SHALL live in one sub-module, tx_bit_timer: a clear/enable counter that emits a wrap pulse at CLKS_PER_BIT-1.
REQ-029 The FSM and shift register SHALL reside in transmitting.

Verification
REQ-030 Reset, then idle 50 cycles -> data_out=1, busy=0, charSent never high.
REQ-031 load=1 for one cycle with data_in=0x55 -> data_out is low for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high for 16 cycles; charSent pulses at cycle 161 after load.
REQ-032 Send 0xA3, then send 0x0F with load asserted in the charSent cycle -> two contiguous frames with a single-cycle gap, and both decode correctly through receiving's loopback.
REQ-033 Hold load=1 with data_in toggling throughout a 0xFF frame -> the frame carries 0xFF only, and a second frame starts only after charSent.
REQ-034 Assert reset at cycle 70 of a frame -> data_out=1 and busy=0 on the next edge, with no charSent pulse.
REQ-035 Set CLKS_PER_BIT=4 and send 0x81 -> each bit is held 4 cycles and the frame length is 40 cycles.
